// File: rtl/var_delay_buffer_pkg.sv
// -----------------------------------------------------------------------------
// var_delay_buffer_pkg
//   Shared defaults for the runtime-programmable delay line and its stream
//   interface. Widths that depend on MAX_DELAY (the RAM address width) are
//   derived locally in each user with $clog2, so this package only carries
//   the default parameter values and the width of the RAM word overhead.
// -----------------------------------------------------------------------------
package var_delay_buffer_pkg;

  // Default sample width in bits.
  localparam int DEF_PRECISION = 4;

  // Default largest programmable delay.
  localparam int DEF_MAX_DELAY = 64;

  // Each RAM word stores the valid tag next to the sample.
  localparam int TAG_BITS = 1;

endpackage : var_delay_buffer_pkg

// File: rtl/var_delay_buffer_if.sv
// -----------------------------------------------------------------------------
// var_delay_buffer_if
//   Sample stream into and out of the delay line.
//   ivalid / idata : input sample and its valid tag (driven by the source)
//   ovalid / odata : delayed sample and its valid tag (driven by the delay line)
//   Modports:
//     master : the stream source/sink around the delay line
//     slave  : the delay line itself
// -----------------------------------------------------------------------------
interface var_delay_buffer_if
  import var_delay_buffer_pkg::*;
#(
  parameter int PRECISION = DEF_PRECISION
);

  logic                 ivalid;
  logic [PRECISION-1:0] idata;
  logic                 ovalid;
  logic [PRECISION-1:0] odata;

  modport master (
    output ivalid,
    output idata,
    input  ovalid,
    input  odata
  );

  modport slave (
    input  ivalid,
    input  idata,
    output ovalid,
    output odata
  );

endinterface : var_delay_buffer_if

// File: rtl/var_delay_buffer_sdp_ram.sv
// -----------------------------------------------------------------------------
// var_delay_buffer_sdp_ram
//   Generic simple-dual-port RAM: one write port, one registered read port,
//   single clock, no reset. Read-during-write to the same address returns the
//   old contents (read-first); callers that need write-first behaviour bypass
//   around it. Reusable for other line buffers.
//   Ports:
//     clk    in  1      clock (rising edge)
//     we     in  1      write enable
//     waddr  in  AW     write address
//     wdata  in  WIDTH  write data
//     raddr  in  AW     read address, sampled on the rising edge
//     rdata  out WIDTH  read data, valid the cycle after raddr is presented
// -----------------------------------------------------------------------------
module var_delay_buffer_sdp_ram #(
  parameter int WIDTH = 5,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [WIDTH-1:0] rdata_r;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port (read-first on address collision).
  always_ff @(posedge clk) begin
    rdata_r <= mem_r[raddr];
  end

  assign rdata = rdata_r;

endmodule : var_delay_buffer_sdp_ram

// File: rtl/var_delay_buffer.sv
// -----------------------------------------------------------------------------
// var_delay_buffer
//   Runtime-programmable delay line. Every cycle the sample and its valid tag
//   are written into a circular RAM; the output is the sample accepted D+1
//   cycles earlier (D = programmed delay, D=0 gives one cycle of latency).
//   After reset or a configuration load the output is held at zero (busy=1)
//   until the first sample accepted after the load reaches the output.
//   Ports:
//     clk        in  1          clock, rising edge
//     rst_n      in  1          asynchronous active-low reset
//     cfg_load   in  1          one-cycle pulse: capture cfg_delay
//     cfg_delay  in  AW         requested delay D (clamped to MAX_DELAY)
//     cfg_err    out 1          one-cycle pulse when the request was clamped
//     busy       out 1          high while the warm-up counter runs
//     stream     slave of var_delay_buffer_if (ivalid/idata in,
//                ovalid/odata out; odata is zero whenever ovalid is zero)
// -----------------------------------------------------------------------------
module var_delay_buffer
  import var_delay_buffer_pkg::*;
#(
  parameter  int PRECISION = DEF_PRECISION,
  parameter  int MAX_DELAY = DEF_MAX_DELAY,
  localparam int AW        = $clog2(MAX_DELAY + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_load,
  input  logic [AW-1:0]     cfg_delay,
  output logic              cfg_err,
  output logic              busy,
  var_delay_buffer_if.slave stream
);

  localparam int            WIDTH    = PRECISION + TAG_BITS;
  localparam logic [AW-1:0] MAX_D    = AW'(MAX_DELAY);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] D_ZERO   = AW'(0);
  localparam logic [AW-1:0] D_ONE    = AW'(1);
  localparam logic [AW:0]   WARM_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   WARM_ZERO = (AW + 1)'(0);

  // Configuration and pointer state.
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        delay_r;
  logic [AW:0]          warm_r;   // one bit wider: MAX_DELAY+1 may equal 2**AW
  logic                 busy_r;
  logic                 cfg_err_r;

  // Datapath.
  logic [WIDTH-1:0]     wdata_s;
  logic [WIDTH-1:0]     prev_r;   // sample written on the previous cycle
  logic [AW-1:0]        rd_addr_s;
  logic [WIDTH-1:0]     ram_q_s;
  logic [WIDTH-1:0]     src_s;
  logic                 mask_s;
  logic                 ovalid_r;
  logic [PRECISION-1:0] odata_r;

  // Clamp logic.
  logic                 req_clamp_s;
  logic [AW-1:0]        req_delay_s;

  // Clamp the requested delay to the largest supported value.
  always_comb begin
    req_clamp_s = (cfg_delay > MAX_D);
    if (req_clamp_s) begin
      req_delay_s = MAX_D;
    end else begin
      req_delay_s = cfg_delay;
    end
  end

  assign wdata_s = {stream.ivalid, stream.idata};

  // The RAM read is registered, so the address is issued one cycle ahead:
  // it is next cycle's wr_ptr minus D. The RAM word then arrives exactly when
  // the output register needs it. For D>=2 the entry was written at least one
  // edge before the read; D=0 and D=1 are served by bypass paths below.
  assign rd_addr_s = wr_ptr_r + PTR_ONE - delay_r;

  var_delay_buffer_sdp_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_sdp_ram (
    .clk   (clk),
    .we    (1'b1),
    .waddr (wr_ptr_r),
    .wdata (wdata_s),
    .raddr (rd_addr_s),
    .rdata (ram_q_s)
  );

  // Select the sample that is due at the output on this edge.
  // D=0: the sample is the one being written right now (write-first bypass).
  // D=1: the RAM read would collide with last cycle's write, so use the copy
  //      of last cycle's input instead.
  always_comb begin
    if (delay_r == D_ZERO) begin
      src_s = wdata_s;
    end else if (delay_r == D_ONE) begin
      src_s = prev_r;
    end else begin
      src_s = ram_q_s;
    end
  end

  // Output is blanked whenever busy will be high next cycle, so ovalid and
  // busy are never high together. A load blanks at once: anything due on the
  // load edge predates the new configuration.
  assign mask_s = cfg_load | (warm_r > WARM_ONE);

  // Write pointer advances every cycle and wraps naturally at 2**AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + PTR_ONE;
    end
  end

  // Copy of the previous input, used by the D=1 bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= {WIDTH{1'b0}};
    end else begin
      prev_r <= wdata_s;
    end
  end

  // Delay register and clamp error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_r   <= {AW{1'b0}};
      cfg_err_r <= 1'b0;
    end else if (cfg_load) begin
      delay_r   <= req_delay_s;
      cfg_err_r <= req_clamp_s;
    end else begin
      delay_r   <= delay_r;
      cfg_err_r <= 1'b0;
    end
  end

  // Warm-up counter: loads D+1 on reset and on every load, counts down to 0.
  // busy_r mirrors (warm_r != 0) as a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_r <= WARM_ONE;
      busy_r <= 1'b1;
    end else if (cfg_load) begin
      warm_r <= {1'b0, req_delay_s} + WARM_ONE;
      busy_r <= 1'b1;
    end else if (warm_r != WARM_ZERO) begin
      warm_r <= warm_r - WARM_ONE;
      busy_r <= (warm_r > WARM_ONE);
    end else begin
      warm_r <= warm_r;
      busy_r <= 1'b0;
    end
  end

  // Output register: data is forced to zero on invalid slots and while masked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovalid_r <= 1'b0;
      odata_r  <= {PRECISION{1'b0}};
    end else if (mask_s) begin
      ovalid_r <= 1'b0;
      odata_r  <= {PRECISION{1'b0}};
    end else if (src_s[WIDTH-1]) begin
      ovalid_r <= 1'b1;
      odata_r  <= src_s[PRECISION-1:0];
    end else begin
      ovalid_r <= 1'b0;
      odata_r  <= {PRECISION{1'b0}};
    end
  end

  assign stream.ovalid = ovalid_r;
  assign stream.odata  = odata_r;
  assign cfg_err       = cfg_err_r;
  assign busy          = busy_r;

endmodule : var_delay_buffer
